m2_block_fetch: RTL and testbench

Parametrised block fetcher for milestone 2. It reads a BLK_W×BLK_H block of 16-bit S' samples from external SRAM at an arbitrary base address and row stride. Samples are packed PACK per word and written sequentially into the dual-port scratchpad RAM that feeds the IDCT stage. It adds three capabilities beyond the fixed 8×8, 2-per-word fetcher: a free row stride (Y and U/V planes share one block), a configurable SRAM read latency, and a synchronous abort.

---
 rtl/m2_block_fetch.sv | 188 ++++++++++++++++++
 tb/tb_m2_block_fetch.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/m2_block_fetch.sv
// Purpose: fetch a BLK_W x BLK_H block of 16-bit samples from SRAM into the IDCT scratchpad, PACK samples per word.
// Latency: element k address loaded k edges after the Start edge; last write + Done at Start edge + N-1+READ_LAT.
// Backpressure: none; one address per cycle once started, Start ignored while Busy, Abort cancels on the next edge.
//
// Ports:
//   CLOCK_50, Resetn          clock, asynchronous active-low reset
//   Start, Abort              level start (sampled in idle), synchronous cancel of an active fetch
//   Base_address, Row_stride  block origin and SRAM words between rows, latched at Start
//   Col_major                 traversal select (only honoured when M2_FETCH_COLMAJOR_EN is defined)
//   SRAM_read_data/_address   SRAM read port, data sampled READ_LAT edges after the address load
//   Busy, Done                active flag, one-cycle completion pulse coincident with the last write
//   address_SP, write_data_SP, wren_SP   scratchpad write port
// Optional feature macro: M2_FETCH_COLMAJOR_EN (column-major traversal, transposed scratchpad layout).
module m2_block_fetch #(
  parameter int BLK_W    = 8,
  parameter int BLK_H    = 8,
  parameter int PACK     = 2,
  parameter int SP_AW    = 7,
  parameter int READ_LAT = 3
) (
  input  logic             CLOCK_50,
  input  logic             Resetn,
  input  logic             Start,
  input  logic             Abort,
  input  logic [17:0]      Base_address,
  input  logic [8:0]       Row_stride,
  input  logic             Col_major,
  input  logic [15:0]      SRAM_read_data,
  output logic [17:0]      SRAM_address,
  output logic             Busy,
  output logic             Done,
  output logic [SP_AW-1:0] address_SP,
  output logic [31:0]      write_data_SP,
  output logic             wren_SP
);

  localparam int N    = BLK_W * BLK_H;
  localparam int NW   = N / PACK;
  localparam int CW   = $clog2(N);
  localparam int LMAX = (BLK_W > BLK_H) ? BLK_W : BLK_H;
  localparam int PW   = $clog2(LMAX);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t               state_q;
  logic [17:0]          sram_addr_q;
  logic [17:0]          line_start_q;   // first address of the current row (or column)
  logic [PW-1:0]        pos_q;          // position inside the current line
  logic [CW-1:0]        elem_q;         // index of the element whose address is on SRAM_address
  logic [8:0]           stride_q;
  logic [READ_LAT-1:0]  vpipe_q;        // one tag per issued address, oldest at the top
  logic                 half_q;         // pair buffer holds the first sample of a pair
  logic [15:0]          buf_q;
  logic [SP_AW-1:0]     wr_idx_q;
  logic [SP_AW-1:0]     sp_addr_q;
  logic [31:0]          wdata_q;
  logic                 wren_q;
  logic                 done_q;
  logic                 busy_q;

`ifdef M2_FETCH_COLMAJOR_EN
  logic                 col_major_q;
`else
  logic                 unused_col_major;
  assign unused_col_major = Col_major;
`endif

  // Next-address generation: a step inside the line, or a jump from the line start.
  // Row-major steps +1 and jumps +stride; column-major swaps the two.
  logic                 line_last;
  logic [17:0]          step_in;
  logic [17:0]          step_out;
  logic [17:0]          addr_d;
  logic [17:0]          line_start_d;
  logic [PW-1:0]        pos_d;

  always_comb begin
    line_last = (pos_q == PW'(BLK_W - 1));
    step_in   = 18'd1;
    step_out  = {9'd0, stride_q};
`ifdef M2_FETCH_COLMAJOR_EN
    if (col_major_q) begin
      line_last = (pos_q == PW'(BLK_H - 1));
      step_in   = {9'd0, stride_q};
      step_out  = 18'd1;
    end
`endif
    addr_d       = sram_addr_q + step_in;
    line_start_d = line_start_q;
    pos_d        = pos_q + PW'(1);
    if (line_last) begin
      addr_d       = line_start_q + step_out;
      line_start_d = line_start_q + step_out;
      pos_d        = '0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q      <= S_IDLE;
      sram_addr_q  <= '0;
      line_start_q <= '0;
      pos_q        <= '0;
      elem_q       <= '0;
      stride_q     <= '0;
      vpipe_q      <= '0;
      half_q       <= 1'b0;
      buf_q        <= '0;
      wr_idx_q     <= '0;
      sp_addr_q    <= '0;
      wdata_q      <= '0;
      wren_q       <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
`ifdef M2_FETCH_COLMAJOR_EN
      col_major_q  <= 1'b0;
`endif
    end else begin
      wren_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            sram_addr_q  <= Base_address;
            line_start_q <= Base_address;
            stride_q     <= Row_stride;
`ifdef M2_FETCH_COLMAJOR_EN
            col_major_q  <= Col_major;
`endif
            pos_q        <= '0;
            elem_q       <= '0;
            vpipe_q      <= READ_LAT'(1);   // element 0 issued on this edge
            half_q       <= 1'b0;
            wr_idx_q     <= '0;
            sp_addr_q    <= '0;
            busy_q       <= 1'b1;
            state_q      <= S_ISSUE;
          end
        end
        default: begin
          if (Abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            vpipe_q <= '0;
            half_q  <= 1'b0;
            buf_q   <= '0;
          end else begin
            vpipe_q <= {vpipe_q[READ_LAT-2:0], (state_q == S_ISSUE)};
            if (state_q == S_ISSUE) begin
              sram_addr_q  <= addr_d;
              line_start_q <= line_start_d;
              pos_q        <= pos_d;
              elem_q       <= elem_q + CW'(1);
              if (elem_q == CW'(N - 2)) state_q <= S_DRAIN;
            end
            // A tag leaving the pipe means SRAM_read_data belongs to an issued element.
            if (vpipe_q[READ_LAT-1]) begin
              if (PACK == 2 && !half_q) begin
                buf_q  <= SRAM_read_data;
                half_q <= 1'b1;
              end else begin
                half_q    <= 1'b0;
                wren_q    <= 1'b1;
                wdata_q   <= (PACK == 2) ? {buf_q, SRAM_read_data}
                                         : {{16{SRAM_read_data[15]}}, SRAM_read_data};
                sp_addr_q <= wr_idx_q;
                wr_idx_q  <= wr_idx_q + SP_AW'(1);
                if (wr_idx_q == SP_AW'(NW - 1)) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
                end
              end
            end
          end
        end
      endcase
    end
  end

  assign SRAM_address  = sram_addr_q;
  assign Busy          = busy_q;
  assign Done          = done_q;
  assign address_SP    = sp_addr_q;
  assign write_data_SP = wdata_q;
  assign wren_SP       = wren_q;

endmodule

// File: tb/tb_m2_block_fetch.sv
// Bench for m2_block_fetch: a PACK=2 instance and a PACK=1 instance, each fed by an SRAM model
// returning addr[15:0] + off with READ_LAT-cycle read latency.
module tb_m2_block_fetch;

  localparam int BW = 8;
  localparam int BH = 8;
  localparam int RL = 3;
  localparam int N  = BW * BH;
  localparam int LAT = N - 1 + RL;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start  [2];
  logic        abort  [2];
  logic        cm     [2];
  logic [17:0] base   [2];
  logic [8:0]  stride [2];
  logic [15:0] off    [2];
  logic [15:0] rdata  [2];
  logic [17:0] sram_addr [2];
  logic        busy  [2];
  logic        done  [2];
  logic        wren  [2];
  logic [6:0]  sp_addr [2];
  logic [31:0] wdata [2];
  logic [17:0] apipe [2][2];

  m2_block_fetch #(.BLK_W(BW), .BLK_H(BH), .PACK(2), .SP_AW(7), .READ_LAT(RL)) u_dut0 (
    .CLOCK_50(clk), .Resetn(rst_n), .Start(start[0]), .Abort(abort[0]),
    .Base_address(base[0]), .Row_stride(stride[0]), .Col_major(cm[0]),
    .SRAM_read_data(rdata[0]), .SRAM_address(sram_addr[0]), .Busy(busy[0]), .Done(done[0]),
    .address_SP(sp_addr[0]), .write_data_SP(wdata[0]), .wren_SP(wren[0]));

  m2_block_fetch #(.BLK_W(BW), .BLK_H(BH), .PACK(1), .SP_AW(7), .READ_LAT(RL)) u_dut1 (
    .CLOCK_50(clk), .Resetn(rst_n), .Start(start[1]), .Abort(abort[1]),
    .Base_address(base[1]), .Row_stride(stride[1]), .Col_major(cm[1]),
    .SRAM_read_data(rdata[1]), .SRAM_address(sram_addr[1]), .Busy(busy[1]), .Done(done[1]),
    .address_SP(sp_addr[1]), .write_data_SP(wdata[1]), .wren_SP(wren[1]));

  // SRAM: address loaded at edge t is returned so that it is sampled at edge t+RL.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      apipe[d][0] <= sram_addr[d];
      apipe[d][1] <= apipe[d][0];
    end
  end
  assign rdata[0] = apipe[0][1][15:0] + off[0];
  assign rdata[1] = apipe[1][1][15:0] + off[1];

  typedef struct packed { logic [6:0] sp; logic [31:0] d; } wr_t;
  wr_t         wq0[$];
  wr_t         wq1[$];
  logic [17:0] alog0[$];
  int          nwr [2];
  int          ndone [2];
  int          done_cyc [2];

  always @(negedge clk) begin
    if (wren[0]) begin wq0.push_back({sp_addr[0], wdata[0]}); nwr[0]++; end
    if (wren[1]) begin wq1.push_back({sp_addr[1], wdata[1]}); nwr[1]++; end
    for (int d = 0; d < 2; d++) if (done[d]) begin ndone[d]++; done_cyc[d] = cyc; end
    if (busy[0]) alog0.push_back(sram_addr[0]);
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [63:0] outs(input int d);
    return {4'd0, sram_addr[d], sp_addr[d], wdata[d], wren[d], done[d], busy[d]};
  endfunction

  // Reference: element k of the traversal, address = base + r*stride + c mod 2^18.
  function automatic logic [17:0] elem_addr(input logic [17:0] b, input logic [8:0] s,
                                            input logic c_m, input int k);
    int r, c;
    if (c_m) begin c = k / BH; r = k % BH; end
    else     begin r = k / BW; c = k % BW; end
    return 18'(int'(b) + r * int'(s) + c);
  endfunction

  function automatic logic [31:0] exp_word(input int sel, input logic [17:0] b, input logic [8:0] s,
                                           input logic c_m, input logic [15:0] o, input int j);
    logic [17:0] a0, a1;
    logic [15:0] v0, v1;
    a0 = elem_addr(b, s, c_m, (sel == 0) ? 2 * j : j);
    a1 = elem_addr(b, s, c_m, 2 * j + 1);
    v0 = a0[15:0] + o;
    v1 = a1[15:0] + o;
    if (sel == 0) return {v0, v1};
    return {{16{v0[15]}}, v0};
  endfunction

  // One fetch with model checks. With noise, Start is pulsed (and Base changed) while Busy.
  task automatic run_fetch(input int sel, input logic [17:0] b, input logic [8:0] s,
                           input logic c_m, input logic noise);
    int   nexp, e0, bad, idx;
    logic fin, c_eff;
    wr_t  q[$];
    wr_t  we;
`ifdef M2_FETCH_COLMAJOR_EN
    c_eff = c_m;
`else
    c_eff = 1'b0;
`endif
    nexp = (sel == 0) ? N / 2 : N;
    @(negedge clk);
    if (sel == 0) begin wq0.delete(); alog0.delete(); end
    else wq1.delete();
    done_cyc[sel] = -1000;
    base[sel] = b; stride[sel] = s; cm[sel] = c_m; start[sel] = 1'b1;
    e0 = cyc + 1;
    fin = 1'b0;
    for (int i = 0; i < 300 && !fin; i++) begin
      @(negedge clk);
      start[sel] = noise && (i == 7 || i == 30);
      if (noise && i == 7) base[sel] = 18'($urandom);
      if (!busy[sel]) fin = 1'b1;
    end
    @(negedge clk);
    chk("fetch_finished", fin, 1);
    if (sel == 0) q = wq0; else q = wq1;
    chk("write_count", q.size(), nexp);
    chk("done_latency", done_cyc[sel] - e0, LAT);
    bad = -1;
    for (int j = 0; j < q.size() && j < nexp; j++) begin
      we = {7'(j), exp_word(sel, b, s, c_eff, off[sel], j)};
      if (q[j] !== we && bad < 0) bad = j;
    end
    if (q.size() > 0) begin
      idx = (bad >= 0) ? bad : ((q.size() < nexp) ? q.size() - 1 : nexp - 1);
      we  = {7'(idx), exp_word(sel, b, s, c_eff, off[sel], idx)};
      chk("write_words", q[idx], we);
    end
    if (sel == 0 && alog0.size() >= N) begin
      bad = N - 1;
      for (int k = N - 1; k >= 0; k--) if (alog0[k] !== elem_addr(b, s, c_eff, k)) bad = k;
      chk("addr_seq", alog0[bad], elem_addr(b, s, c_eff, bad));
    end
  endtask

  typedef struct {
    int          sel;
    logic [17:0] b;
    logic [8:0]  s;
    logic        c_m;
    logic [15:0] o;
    int          widx;
    logic [31:0] w;
  } vec_t;

  initial begin
    vec_t vt[$];
    int   e0, w0, d0, sel;
    logic got;
    wr_t  gw;

    vt.push_back('{0, 18'd76800, 9'd320, 1'b0, 16'h0000, 0,  32'h2C00_2C01});
    vt.push_back('{0, 18'd76800, 9'd320, 1'b0, 16'h0000, 4,  32'h2D40_2D41});
    vt.push_back('{0, 18'd76800, 9'd320, 1'b0, 16'h0000, 31, 32'h34C6_34C7});
    vt.push_back('{1, 18'd38400, 9'd160, 1'b0, 16'hEA00, 0,  32'hFFFF_8000});
    vt.push_back('{1, 18'd38400, 9'd160, 1'b0, 16'hEA00, 8,  32'hFFFF_80A0});
    vt.push_back('{1, 18'd38400, 9'd160, 1'b0, 16'hEA00, 63, 32'hFFFF_8467});
`ifdef M2_FETCH_COLMAJOR_EN
    vt.push_back('{0, 18'd0, 9'd320, 1'b1, 16'h0000, 0, 32'h0000_0140});
    vt.push_back('{0, 18'd0, 9'd320, 1'b1, 16'h0000, 4, 32'h0001_0141});
`endif

    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; abort[d] = 1'b0; cm[d] = 1'b0;
      base[d] = '0; stride[d] = '0; off[d] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs_dut0", outs(0), 64'd0);
    chk("reset_outs_dut1", outs(1), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven fetches with hand-derived words.
    foreach (vt[i]) begin
      off[vt[i].sel] = vt[i].o;
      run_fetch(vt[i].sel, vt[i].b, vt[i].s, vt[i].c_m, 1'b0);
      gw = '0;
      if (vt[i].sel == 0 && wq0.size() > vt[i].widx) gw = wq0[vt[i].widx];
      if (vt[i].sel == 1 && wq1.size() > vt[i].widx) gw = wq1[vt[i].widx];
      chk($sformatf("vec%0d_word%0d", i, vt[i].widx), gw, {7'(vt[i].widx), vt[i].w});
    end

    // Randomized fetches against the model; dut0 also sees Start pulses while Busy.
    for (int it = 0; it < 6; it++) begin
      sel = it % 2;
      off[sel] = 16'($urandom);
      run_fetch(sel, 18'($urandom), 9'($urandom), 1'($urandom), sel == 0);
    end

    // Start held high: next fetch begins on the edge after the Done cycle.
    @(negedge clk);
    off[0] = '0; base[0] = 18'd76800; stride[0] = 9'd320; cm[0] = 1'b0; start[0] = 1'b1;
    e0 = cyc + 1;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (done[0]) got = 1'b1;
    end
    chk("b2b_first_done", got, 1);
    chk("b2b_done_cycle", cyc - e0, LAT);
    base[0] = 18'h00100;
    @(negedge clk);
    chk("b2b_restart", {busy[0], sram_addr[0]}, {1'b1, 18'h00100});
    start[0] = 1'b0;
    e0 = cyc;
    for (int i = 0; i < 200 && busy[0]; i++) @(negedge clk);
    @(negedge clk);
    chk("b2b_second_done", done_cyc[0] - e0, LAT);

    // Abort mid-fetch on what would otherwise be a write edge.
    @(negedge clk);
    base[0] = 18'd1000; stride[0] = 9'd320; start[0] = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    start[0] = 1'b0;
    while (cyc < e0 + 11) @(negedge clk);
    abort[0] = 1'b1;
    w0 = nwr[0]; d0 = ndone[0];
    @(negedge clk);
    abort[0] = 1'b0;
    chk("abort_stop", {busy[0], wren[0]}, 2'b00);
    repeat (80) @(negedge clk);
    chk("abort_no_done", ndone[0], d0);
    chk("abort_no_writes", nwr[0], w0);
    run_fetch(0, 18'd2000, 9'd160, 1'b0, 1'b0);
    chk("abort_restart_sp0", (wq0.size() > 0) ? {1'b0, wq0[0].sp} : 8'hFF, 8'd0);

    // Reset pulsed during DRAIN.
    @(negedge clk);
    base[0] = 18'd5000; stride[0] = 9'd320; start[0] = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    start[0] = 1'b0;
    while (cyc < e0 + 64) @(negedge clk);
    chk("drain_busy", busy[0], 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_drain_outs", outs(0), 64'd0);
    w0 = nwr[0]; d0 = ndone[0];
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_no_write", nwr[0], w0);
    chk("rst_no_done", ndone[0], d0);
    chk("rst_idle_outs", outs(0), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
